// File: rtl/io_output.sv
// Memory-mapped output ports (0x80/0x84/0x88) with per-write strobes and an
// 8-digit multiplexed 7-segment scan of out_port2. Optional readback: IO_OUTPUT_READBACK_EN.

module io_port_reg #(
  parameter int W = 32
) (
  input  logic         io_clk,
  input  logic         resetn,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] q,
  output logic         stb
);

  // Strobe follows every accepted write, even when the value is unchanged.
  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      q   <= '0;
      stb <= 1'b0;
    end else begin
      stb <= wr_en;
      if (wr_en) q <= wr_data;
    end
  end

endmodule

module io_output #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_enable,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [2:0]  out_strobe,
  output logic [7:0]  seg_sel,
  output logic [6:0]  seg_code,
  output logic [31:0] io_rdata
);

  localparam int          NUM_PORTS = 3;
  localparam logic [5:0]  PORT_BASE = 6'b100000;
  localparam int          CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef struct packed {
    logic [5:0]  sel;
    logic [31:0] data;
    logic        en;
  } io_wr_req_t;

  io_wr_req_t                        wr_req;
  logic [NUM_PORTS-1:0]              port_hit;
  logic [NUM_PORTS-1:0][31:0]        port_q;
  logic [NUM_PORTS-1:0]              port_stb;
  logic                              addr_unused;

  assign wr_req.sel  = addr[7:2];
  assign wr_req.data = datain;
  assign wr_req.en   = write_io_enable;
  assign addr_unused = ^{addr[31:8], addr[1:0]};

  always_comb begin
    port_hit = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      port_hit[i] = wr_req.en && (wr_req.sel == (PORT_BASE + 6'(i)));
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_port
      io_port_reg #(.W(32)) u_port (
        .io_clk  (io_clk),
        .resetn  (resetn),
        .wr_en   (port_hit[g]),
        .wr_data (wr_req.data),
        .q       (port_q[g]),
        .stb     (port_stb[g])
      );
    end
  endgenerate

  assign out_port0  = port_q[0];
  assign out_port1  = port_q[1];
  assign out_port2  = port_q[2];
  assign out_strobe = port_stb;

  // Display scan: digit index advances once per SCAN_DIV cycles.
  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       digit_idx;
  logic             scan_wrap;
  logic [2:0]       digit_nxt;
  logic [3:0]       nibble;

  assign scan_wrap = (scan_cnt == CNT_LAST);
  assign digit_nxt = digit_idx + 3'd1;
  assign nibble    = port_q[2][{digit_idx, 2'b00} +: 4];

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
      seg_sel   <= 8'hFE;
      seg_code  <= 7'b1111111;
    end else begin
      // Segment code tracks the live port value; a mid-digit write shows next cycle.
      seg_code <= hex_decode(nibble);
      if (scan_wrap) begin
        scan_cnt  <= '0;
        digit_idx <= digit_nxt;
        seg_sel   <= ~(8'b1 << digit_nxt);
      end else begin
        scan_cnt  <= scan_cnt + 1'b1;
      end
    end
  end

`ifdef IO_OUTPUT_READBACK_EN
  always_comb begin
    io_rdata = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (wr_req.sel == (PORT_BASE + 6'(i))) io_rdata = port_q[i];
  end
`else
  assign io_rdata = '0;
`endif

endmodule

// File: tb/tb_io_output.sv
// Directed bench for io_output: port writes/strobes, decode, scan timing, reset priority.

module tb_io_output;

  logic        io_clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        write_io_enable;
  logic [31:0] out_port0, out_port1, out_port2;
  logic [2:0]  out_strobe;
  logic [7:0]  seg_sel;
  logic [6:0]  seg_code;
  logic [31:0] io_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] seg_tbl [8] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000,
                              7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
  logic [7:0] sel_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  io_output #(.SCAN_DIV(4)) dut (
    .io_clk          (io_clk),
    .resetn          (resetn),
    .addr            (addr),
    .datain          (datain),
    .write_io_enable (write_io_enable),
    .out_port0       (out_port0),
    .out_port1       (out_port1),
    .out_port2       (out_port2),
    .out_strobe      (out_strobe),
    .seg_sel         (seg_sel),
    .seg_code        (seg_code),
    .io_rdata        (io_rdata)
  );

  always #5 io_clk = ~io_clk;

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; addr = '0; datain = '0; write_io_enable = 1'b0;
    tick(); tick();
    chk("rst_port0", out_port0, 32'h0);
    chk("rst_port1", out_port1, 32'h0);
    chk("rst_port2", out_port2, 32'h0);
    chk("rst_strobe", {29'h0, out_strobe}, 32'h0);
    chk("rst_sel", {24'h0, seg_sel}, 32'hFE);
    chk("rst_code", {25'h0, seg_code}, 32'h7F);

    // Single write to port0
    resetn = 1'b1; addr = 32'h80; datain = 32'hDEADBEEF; write_io_enable = 1'b1;
    tick(); write_io_enable = 1'b0;
    chk("w0_port0", out_port0, 32'hDEADBEEF);
    chk("w0_strobe", {29'h0, out_strobe}, 32'h1);
    chk("w0_port1", out_port1, 32'h0);
    chk("w0_port2", out_port2, 32'h0);
    tick();
    chk("w0_strobe_off", {29'h0, out_strobe}, 32'h0);
    chk("w0_hold", out_port0, 32'hDEADBEEF);

    // Back-to-back and identical rewrites to port1; upper address bits ignored
    addr = 32'hFFFF_FF84; datain = 32'h11111111; write_io_enable = 1'b1;
    tick();
    chk("b2b_a_port1", out_port1, 32'h11111111);
    chk("b2b_a_strobe", {29'h0, out_strobe}, 32'h2);
    datain = 32'h22222222;
    tick();
    chk("b2b_b_port1", out_port1, 32'h22222222);
    chk("b2b_b_strobe", {29'h0, out_strobe}, 32'h2);
    tick();
    chk("same_strobe", {29'h0, out_strobe}, 32'h2);
    chk("same_port1", out_port1, 32'h22222222);
    write_io_enable = 1'b0;
    tick();
    chk("b2b_strobe_off", {29'h0, out_strobe}, 32'h0);

    // Unmapped addresses
    addr = 32'h8C; datain = 32'h12345678; write_io_enable = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("unmap_strobe", {29'h0, out_strobe}, 32'h0);
      chk("unmap_port0", out_port0, 32'hDEADBEEF);
      chk("unmap_port1", out_port1, 32'h22222222);
      chk("unmap_port2", out_port2, 32'h0);
      addr = 32'hC0;
    end
    addr = 32'h80; write_io_enable = 1'b0;
    tick();
    chk("noen_port0", out_port0, 32'hDEADBEEF);
    chk("noen_strobe", {29'h0, out_strobe}, 32'h0);

    // Readback mux
    addr = 32'h80; #1;
`ifdef IO_OUTPUT_READBACK_EN
    chk("rd_port0", io_rdata, 32'hDEADBEEF);
`else
    chk("rd_port0", io_rdata, 32'h0);
`endif
    addr = 32'h90; #1;
    chk("rd_unmap", io_rdata, 32'h0);

    // Scan sequence; write lands on the first edge out of reset
    resetn = 1'b0; tick(); tick();
    resetn = 1'b1; addr = 32'h88; datain = 32'h0123ABCD; write_io_enable = 1'b1;
    tick(); write_io_enable = 1'b0;
    chk("scan_port2", out_port2, 32'h0123ABCD);
    for (int e = 1; e <= 36; e++) begin
      tick();
      if (e % 4 == 2) begin
        chk("scan_sel", {24'h0, seg_sel}, {24'h0, sel_tbl[(e / 4) % 8]});
        chk("scan_code", {25'h0, seg_code}, {25'h0, seg_tbl[(e / 4) % 8]});
      end
      if (e == 1) chk("scan_code_first", {25'h0, seg_code}, 32'h21);
      if (e == 3) chk("scan_step", {24'h0, seg_sel}, 32'hFD);
    end

    // Mid-digit write to port2 while digit 1 is showing
    datain = 32'h0000_00E0; write_io_enable = 1'b1;
    tick(); write_io_enable = 1'b0;
    chk("mid_port2", out_port2, 32'h000000E0);
    chk("mid_code_old", {25'h0, seg_code}, 32'h46);
    chk("mid_sel", {24'h0, seg_sel}, 32'hFD);
    tick();
    chk("mid_code_new", {25'h0, seg_code}, 32'h06);
    chk("mid_sel_hold", {24'h0, seg_sel}, 32'hFD);
    tick();
    chk("mid_sel_next", {24'h0, seg_sel}, 32'hFB);
    #1;
`ifdef IO_OUTPUT_READBACK_EN
    chk("rd_port2", io_rdata, 32'h000000E0);
`else
    chk("rd_port2", io_rdata, 32'h0);
`endif

    // Reset beats a simultaneous write and restarts the scan
    resetn = 1'b0; addr = 32'h84; datain = 32'hAAAA5555; write_io_enable = 1'b1;
    tick(); write_io_enable = 1'b0;
    chk("rstw_port1", out_port1, 32'h0);
    chk("rstw_port2", out_port2, 32'h0);
    chk("rstw_strobe", {29'h0, out_strobe}, 32'h0);
    chk("rstw_sel", {24'h0, seg_sel}, 32'hFE);
    chk("rstw_code", {25'h0, seg_code}, 32'h7F);
    resetn = 1'b1;
    tick(); tick(); tick();
    chk("rel_hold", {24'h0, seg_sel}, 32'hFE);
    tick();
    chk("rel_step", {24'h0, seg_sel}, 32'hFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
